clk_switch_ctrl: RTL and testbench
==================================

Name: clk_switch_ctrl

Overview:
- Requester side of the glitch-free clock mux: accepts software or PMU clock-switch requests and drives the mux `sel` input.
- Confirms each switch against the mux's exported selection (`clk_sel_out`), waits a settle interval, then reports completion.
- On timeout it reverts, and on a second timeout it latches a fault.
- Lives in the master (clk1) domain, the same domain the mux samples `sel` in, so no synchronisers are needed.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles to wait for `sel_ack` to match `sel` after `sel` is driven.
- SETTLE_CYCLES, 8: cycles to wait after ack match before declaring done; must be ≥1.
- CNT_W, 8: counter width; must hold max(TIMEOUT_CYCLES, SETTLE_CYCLES).

Ports:
- clk  in  1  master clock (the clk1 domain of the mux)
- res  in  1  synchronous reset, active-high
- req  in  1  switch request, sampled only in IDLE
- req_sel  in  1  target selection: 0 = clk1, 1 = clk2
- sel_ack  in  1  mux `clk_sel_out`, already synchronous to clk
- sel  out  1  registered select to the mux
- cur_sel  out  1  last confirmed selection
- busy  out  1  high in any state other than IDLE and FAULT
- done  out  1  one-cycle pulse when a switch completes
- err  out  1  one-cycle pulse when a switch failed and was reverted
- req_drop  out  1  one-cycle pulse when req is high while not in IDLE
- fault  out  1  sticky; cleared only by res

Behaviour:
- Uses one clock with a synchronous, active-high reset. When `res`=1 at a clk edge:
  - state=IDLE, counter=0.
  - Outputs: sel=0, cur_sel=0, busy=0, done=0, err=0, req_drop=0, fault=0.
- Reset mid-operation aborts immediately: no done/err pulse, and sel returns to 0.
- All outputs are registered.
- States: IDLE, WAIT_ACK, SETTLE, REVERT, FAULT.
- IDLE:
  - req=1 and req_sel==cur_sel: go to SETTLE directly, sel unchanged, counter=0. This no-op switch still completes after the settle interval.
  - req=1 and req_sel!=cur_sel: sel<=req_sel, counter<=0, go to WAIT_ACK. busy=1 from the next cycle.
- WAIT_ACK:
  - Counter increments each cycle.
  - sel_ack==sel: counter<=0, go to SETTLE.
  - Otherwise, counter==TIMEOUT_CYCLES-1: sel<=cur_sel (revert), counter<=0, go to REVERT.
  - Ack takes priority over timeout when both occur in the same cycle.
- SETTLE:
  - Counter increments each cycle.
  - counter==SETTLE_CYCLES-1: cur_sel<=sel, done pulse, go to IDLE.
  - If sel_ack deviates from sel during SETTLE, restart WAIT_ACK with counter=0 (mux re-switching).
- REVERT:
  - Waits for sel_ack==sel with the same timeout.
  - Match: err pulse, go to IDLE; cur_sel is unchanged.
  - Timeout: fault<=1, go to FAULT.
- FAULT:
  - Terminal until res.
  - busy=0; sel holds its last value; all requests produce req_drop.
- req_drop: pulses in any cycle where req=1 and state!=IDLE. The request is discarded, not queued.
- Latency:
  - The req edge in IDLE updates sel on the same clk edge, visible the next cycle.
  - Minimum switch time req→done is 1 + ack cycles + SETTLE_CYCLES.
  - No-op request: done asserted SETTLE_CYCLES+1 cycles after req.
- done and err are never asserted in the same cycle. busy is deasserted in the same cycle done or err pulses.
- Counter saturates; it never wraps.

Test Plan:
- Reset, then idle 10 cycles → sel=0, cur_sel=0, busy=0, no pulses.
- req=1, req_sel=1; sel_ack driven 1 five cycles after sel rises → sel=1 next cycle; done pulses exactly 8 cycles after ack match; cur_sel=1; busy low in the done cycle.
- req=1, req_sel=1; sel_ack held 0 → timeout after 64 cycles, sel returns to 0; ack already 0, so err pulses next cycle; cur_sel=0; no done.
- req_sel=1 with sel_ack stuck at 1 after a reverted attempt, so the revert also times out → fault=1 after a second 64 cycles, busy=0; subsequent req gives req_drop; only res clears fault.
- During WAIT_ACK, pulse req=1 → req_drop one cycle; the switch continues unaffected. Then issue req_sel==cur_sel → done 9 cycles later, sel never toggles.
- Assert res during SETTLE → next cycle sel=0, cur_sel=0, busy=0, no done/err pulse.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Requester side of a glitch-free clock mux: drives the mux select, confirms it against
// the mux's exported selection, waits a settle interval, and reverts or faults on timeout.
module clk_switch_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETTLE_CYCLES  = 8,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req,
  input  logic       req_sel,
  input  logic       sel_ack,
  output logic       sel,
  output logic       cur_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       req_drop,
  output logic       fault,
  output logic [2:0] state_dbg
);

  // Request handshake: req is a level sampled only in IDLE; any req seen elsewhere
  // is discarded and reported by a one-cycle req_drop pulse, never queued.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_SETTLE   = 3'd2,
    S_REVERT   = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             cur_sel_q, cur_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_drop_q, req_drop_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    sel_d      = sel_q;
    cur_sel_d  = cur_sel_q;
    fault_d    = fault_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    req_drop_d = req && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (req) begin
          cnt_d = '0;
          if (req_sel == cur_sel_q) begin
            state_d = S_SETTLE;
          end else begin
            sel_d   = req_sel;
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        // Ack wins over timeout when both land on the same cycle.
        if (sel_ack == sel_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          sel_d   = cur_sel_q;
          cnt_d   = '0;
          state_d = S_REVERT;
        end
      end
      S_SETTLE: begin
        // The mux re-switching under us restarts the acknowledge wait.
        if (sel_ack != sel_q) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end else if (cnt_q == ST_LAST) begin
          cur_sel_d = sel_q;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      S_REVERT: begin
        if (sel_ack == sel_q) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_WAIT_ACK) || (state_d == S_SETTLE) || (state_d == S_REVERT);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      cur_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_drop_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      cur_sel_q  <= cur_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      req_drop_q <= req_drop_d;
      fault_q    <= fault_d;
    end
  end

  assign sel       = sel_q;
  assign cur_sel   = cur_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_drop  = req_drop_q;
  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: a table of per-cycle vectors plus hand-written
// multi-cycle sequences, all checked through an expected-value queue.
module tb_clk_switch_ctrl;

  localparam int W = 7;  // {sel, cur_sel, busy, done, err, req_drop, fault}

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       req = 1'b0;
  logic       req_sel = 1'b0;
  logic       sel_ack = 1'b0;
  logic       sel, cur_sel, busy, done, err, req_drop, fault;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic         req;
    logic         req_sel;
    logic         sel_ack;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  clk_switch_ctrl #(.TIMEOUT_CYCLES(64), .SETTLE_CYCLES(8), .CNT_W(8)) dut (
    .clk      (clk),
    .res      (res),
    .req      (req),
    .req_sel  (req_sel),
    .sel_ack  (sel_ack),
    .sel      (sel),
    .cur_sel  (cur_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .req_drop (req_drop),
    .fault    (fault),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] o(input logic s, c, b, d = 1'b0, e = 1'b0,
                                      r = 1'b0, f = 1'b0);
    return {s, c, b, d, e, r, f};
  endfunction

  task automatic check(input string name);
    logic [W-1:0] e;
    logic [W-1:0] act;
    e   = exp_q.pop_front();
    act = {sel, cur_sel, busy, done, err, req_drop, fault};
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (sel cur_sel busy done err req_drop fault) t=%0t",
               name, act, e, $time);
    end
  endtask

  // Drive one cycle of inputs, expect the outputs registered at the following edge.
  task automatic cyc(input logic rq, rs, ak, input logic [W-1:0] exp, input string name);
    req     = rq;
    req_sel = rs;
    sel_ack = ak;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic add(input logic rq, rs, ak, input logic [W-1:0] exp, input string name);
    vec_t v;
    v.req = rq; v.req_sel = rs; v.sel_ack = ak; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input string name);
    res = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, name);
    res = 1'b0;
  endtask

  initial begin
    // Clean switch 0->1 with a late ack, then a fast switch back to 0.
    add(1, 1, 0, o(1, 0, 1), "sw1_req");
    for (int i = 0; i < 4; i++) add(0, 1, 0, o(1, 0, 1), "sw1_wait");
    add(0, 1, 1, o(1, 0, 1), "sw1_ack");
    for (int i = 0; i < 7; i++) add(0, 1, 1, o(1, 0, 1), "sw1_settle");
    add(0, 1, 1, o(1, 1, 0, 1), "sw1_done");
    add(0, 1, 1, o(1, 1, 0), "sw1_idle");
    add(1, 0, 1, o(0, 1, 1), "sw0_req");
    add(0, 0, 0, o(0, 1, 1), "sw0_ack");
    for (int i = 0; i < 7; i++) add(0, 0, 0, o(0, 1, 1), "sw0_settle");
    add(0, 0, 0, o(0, 0, 0, 1), "sw0_done");
    add(0, 0, 0, o(0, 0, 0), "sw0_idle");

    do_reset("reset0");
    do_reset("reset1");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, '0, "idle");

    foreach (tbl[i]) cyc(tbl[i].req, tbl[i].req_sel, tbl[i].sel_ack, tbl[i].exp, tbl[i].name);

    // Ack never arrives: revert after 64 cycles, ack already matches so err next cycle.
    cyc(1, 1, 0, o(1, 0, 1), "to_req");
    for (int i = 0; i < 63; i++) cyc(0, 0, 0, o(1, 0, 1), "to_wait");
    cyc(0, 0, 0, o(0, 0, 1), "to_revert");
    cyc(0, 0, 0, o(0, 0, 0, 0, 1), "to_err");
    cyc(0, 0, 0, o(0, 0, 0), "to_idle");

    // Ack sticks at 1 once reverted: revert also times out and faults.
    cyc(1, 1, 0, o(1, 0, 1), "f_req");
    for (int i = 0; i < 63; i++) cyc(0, 0, 0, o(1, 0, 1), "f_wait");
    cyc(0, 0, 0, o(0, 0, 1), "f_revert");
    for (int i = 0; i < 63; i++) cyc(0, 0, 1, o(0, 0, 1), "f_revert_wait");
    cyc(0, 0, 1, o(0, 0, 0, 0, 0, 0, 1), "f_fault");
    cyc(1, 1, 1, o(0, 0, 0, 0, 0, 1, 1), "f_drop");
    cyc(0, 1, 1, o(0, 0, 0, 0, 0, 0, 1), "f_hold");
    cyc(1, 0, 0, o(0, 0, 0, 0, 0, 1, 1), "f_drop2");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, o(0, 0, 0, 0, 0, 0, 1), "f_sticky");
    do_reset("f_reset");
    cyc(0, 0, 0, '0, "f_clear");

    // A req during WAIT_ACK is dropped; the pending switch completes unchanged.
    cyc(1, 1, 0, o(1, 0, 1), "d_req");
    cyc(1, 0, 0, o(1, 0, 1, 0, 0, 1), "d_drop");
    cyc(0, 0, 0, o(1, 0, 1), "d_wait");
    cyc(0, 0, 1, o(1, 0, 1), "d_ack");
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, o(1, 0, 1), "d_settle");
    cyc(0, 0, 1, o(1, 1, 0, 1), "d_done");

    // No-op request: sel never moves, done 9 cycles after the req cycle.
    cyc(1, 1, 1, o(1, 1, 1), "noop_req");
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, o(1, 1, 1), "noop_settle");
    cyc(0, 1, 1, o(1, 1, 0, 1), "noop_done");
    cyc(0, 1, 1, o(1, 1, 0), "noop_idle");

    // Ack drops mid-settle: wait restarts, settle interval starts over.
    cyc(1, 0, 1, o(0, 1, 1), "dv_req");
    cyc(0, 0, 0, o(0, 1, 1), "dv_ack");
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, o(0, 1, 1), "dv_settle");
    cyc(0, 0, 1, o(0, 1, 1), "dv_glitch");
    cyc(0, 0, 0, o(0, 1, 1), "dv_reack");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, o(0, 1, 1), "dv_resettle");
    cyc(0, 0, 0, o(0, 0, 0, 1), "dv_done");

    // Ack arrives on the very cycle the timeout would fire: ack wins.
    cyc(1, 1, 0, o(1, 0, 1), "pri_req");
    for (int i = 0; i < 63; i++) cyc(0, 1, 0, o(1, 0, 1), "pri_wait");
    cyc(0, 1, 1, o(1, 0, 1), "pri_ack");
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, o(1, 0, 1), "pri_settle");
    cyc(0, 1, 1, o(1, 1, 0, 1), "pri_done");

    // Reset in SETTLE aborts with no pulse afterwards.
    cyc(1, 0, 1, o(0, 1, 1), "rs_req");
    cyc(0, 0, 0, o(0, 1, 1), "rs_ack");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, o(0, 1, 1), "rs_settle");
    do_reset("rs_reset");
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, '0, "rs_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
